// File: rtl/chip7458_selftest_seq.sv
// Exhaustive self-test sequencer for one 7458 AND-OR gate: sweeps all 1024 input vectors and scores p1y/p2y.
// Optional build macro CHIP7458_SEQ_STOP_ON_ERR_EN ends the run at the first mismatching vector.
module chip7458_selftest_seq #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [5:0]       drv_p1,
    output logic [3:0]       drv_p2,
    input  logic             mon_p1y,
    input  logic             mon_p2y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [9:0]       first_err_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [9:0] VEC_LAST    = 10'h3FF;

    state_t           state_q, state_d;
    logic [9:0]       vec_q, vec_d;
    logic [3:0]       settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fev_q, fev_d;
    logic [9:0]       fvec_q, fvec_d;
    logic             pass_q, pass_d;

    logic exp_p1y, exp_p2y, mismatch, stop_now;

    // Golden model evaluated on the registered vector, i.e. exactly what the gate sees.
    assign exp_p1y  = (vec_q[0] & vec_q[1] & vec_q[2]) | (vec_q[3] & vec_q[4] & vec_q[5]);
    assign exp_p2y  = (vec_q[6] & vec_q[7]) | (vec_q[8] & vec_q[9]);
    assign mismatch = (mon_p1y != exp_p1y) || (mon_p2y != exp_p2y);

`ifdef CHIP7458_SEQ_STOP_ON_ERR_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        fev_d    = fev_q;
        fvec_d   = fvec_q;
        pass_d   = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d    = '0;
                    fev_d    = 1'b0;
                    fvec_d   = '0;
                    pass_d   = 1'b0;
                    vec_d    = '0;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    vec_d    = '0;
                    settle_d = '0;
                    pass_d   = 1'b0;
                    state_d  = IDLE;
                end else if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = CHECK;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            CHECK: begin
                if (abort) begin
                    vec_d   = '0;
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (mismatch) begin
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!fev_q) begin
                            fev_d  = 1'b1;
                            fvec_d = vec_q;
                        end
                    end
                    // pass is decided here so it already includes this final check.
                    if ((vec_q == VEC_LAST) || stop_now) begin
                        pass_d  = (err_d == '0);
                        state_d = DONE;
                    end else begin
                        vec_d   = vec_q + 10'd1;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                vec_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            fev_q    <= 1'b0;
            fvec_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fev_q    <= fev_d;
            fvec_q   <= fvec_d;
            pass_q   <= pass_d;
        end
    end

    assign drv_p1          = vec_q[5:0];
    assign drv_p2          = vec_q[9:6];
    assign busy            = (state_q == SETTLE) || (state_q == CHECK);
    assign done            = (state_q == DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fvec_q;

endmodule
